// File: rtl/sram_cache.sv
// Two-way set-associative, write-through, no-write-allocate word cache in front of the SRAM controller.
// Read hits are served combinationally with no stall; misses and all stores freeze the pipeline for one SRAM transaction.
module sram_cache #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic        sram_mem_read,
  output logic        sram_mem_write,
  output logic [17:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_freeze
);

  localparam int SETS = 1 << INDEX_W;
  localparam int WA_W = INDEX_W + TAG_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

  state_t             state;
  logic [SETS-1:0]    valid0, valid1, lru;
  logic [TAG_W-1:0]   tag0 [SETS];
  logic [TAG_W-1:0]   tag1 [SETS];
  logic [31:0]        data0 [SETS];
  logic [31:0]        data1 [SETS];
  logic [31:0]        resp_data;
  logic               resp_rd;

  logic [WA_W-1:0]    word_addr;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, hit, hit_way, victim;
  logic               fill, wr_upd;
  logic               unused_addr_bits;

  assign word_addr        = address[WA_W+1:2];
  assign unused_addr_bits = ^{address[31:WA_W+2], address[1:0]};
  assign index            = word_addr[INDEX_W-1:0];
  assign tag              = word_addr[WA_W-1:INDEX_W];

  assign hit0    = valid0[index] && (tag0[index] == tag);
  assign hit1    = valid1[index] && (tag1[index] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;
  // Fill an empty way first; only fall back to LRU when the set is full.
  assign victim  = !valid0[index] ? 1'b0 : (!valid1[index] ? 1'b1 : lru[index]);

  assign fill   = (state == RD_MISS) && !sram_freeze;
  assign wr_upd = (state == WR_THRU) && !sram_freeze && hit;

  assign sram_address = {word_addr, 1'b0};
  assign sram_wdata   = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      valid0         <= '0;
      valid1         <= '0;
      lru            <= '0;
      sram_mem_read  <= 1'b0;
      sram_mem_write <= 1'b0;
      resp_data      <= '0;
      resp_rd        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_w_en) begin
            state          <= WR_THRU;
            sram_mem_write <= 1'b1;
          end else if (mem_r_en && !hit) begin
            state         <= RD_MISS;
            sram_mem_read <= 1'b1;
          end else if (mem_r_en) begin
            lru[index] <= ~hit_way;
          end
        end
        RD_MISS: begin
          if (!sram_freeze) begin
            sram_mem_read <= 1'b0;
            resp_data     <= sram_rdata;
            resp_rd       <= 1'b1;
            lru[index]    <= ~victim;
            if (victim) valid1[index] <= 1'b1;
            else        valid0[index] <= 1'b1;
            state <= RESP;
          end
        end
        WR_THRU: begin
          if (!sram_freeze) begin
            sram_mem_write <= 1'b0;
            resp_rd        <= 1'b0;
            if (hit) lru[index] <= ~hit_way;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity alone gates their contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill) begin
        if (victim) begin
          tag1[index]  <= tag;
          data1[index] <= sram_rdata;
        end else begin
          tag0[index]  <= tag;
          data0[index] <= sram_rdata;
        end
      end else if (wr_upd) begin
        if (hit_way) data1[index] <= wdata;
        else         data0[index] <= wdata;
      end
    end
  end

  always_comb begin
    rdata  = '0;
    freeze = 1'b0;
    case (state)
      IDLE: begin
        freeze = mem_w_en | (mem_r_en & ~hit);
        if (hit0)      rdata = data0[index];
        else if (hit1) rdata = data1[index];
      end
      RD_MISS, WR_THRU: freeze = 1'b1;
      RESP: if (resp_rd) rdata = resp_data;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_cache.sv
// Bench for sram_cache: a 6-cycle SRAM controller model, a directed request driver, and an rdata scoreboard.
module tb_sram_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic        freeze, sram_mem_read, sram_mem_write;
  logic [17:0] sram_address;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_freeze;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sram_cache dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .freeze(freeze),
    .sram_mem_read(sram_mem_read), .sram_mem_write(sram_mem_write),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_freeze(sram_freeze)
  );

  // SRAM controller model: busy for 5 cycles, finishes on the 6th.
  logic [31:0] mem [0:1023];
  logic [2:0]  cnt;
  assign sram_freeze = (sram_mem_read | sram_mem_write) && (cnt != 3'd5);
  assign sram_rdata  = mem[sram_address[9:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (sram_mem_read | sram_mem_write) cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
  end

  always @(posedge clk) begin
    if (!rst && sram_mem_write && cnt == 3'd5) mem[sram_address[9:0]] <= sram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every released request (enable high, freeze low) consumes one expected rdata.
  always @(negedge clk) begin
    if (!rst && (mem_r_en || mem_w_en) && !freeze) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_response: rdata 0x%08h with empty scoreboard", rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, rdata, e.data);
      end
    end
  end

  task automatic do_req(input string name, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input int exp_frz,
                        input int exp_rd, input int exp_wr);
    int n_frz, n_rd, n_wr, n_badaddr;
    bit done;
    exp_t e;
    n_frz = 0; n_rd = 0; n_wr = 0; n_badaddr = 0; done = 0;
    mem_r_en = r; mem_w_en = w; address = addr; wdata = wd;
    e.name = name; e.data = exp_rdata;
    sb.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (sram_mem_read)  n_rd++;
      if (sram_mem_write) n_wr++;
      if ((sram_mem_read || sram_mem_write) && sram_address != {addr[18:2], 1'b0}) n_badaddr++;
      if (freeze) n_frz++;
      else done = 1;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_freeze_cycles"}, n_frz, exp_frz);
    check({name, "_sram_read_cycles"}, n_rd, exp_rd);
    check({name, "_sram_write_cycles"}, n_wr, exp_wr);
    if (exp_rd + exp_wr > 0) check({name, "_sram_address_errs"}, n_badaddr, 0);
    @(posedge clk);
    #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h000] = 32'h11110000;
    mem[10'h080] = 32'hDEADBEEF;
    mem[10'h100] = 32'h22220200;
    mem[10'h180] = 32'h33330300;

    #2;
    check("reset_sram_mem_read", {31'd0, sram_mem_read}, 32'd0);
    check("reset_sram_mem_write", {31'd0, sram_mem_write}, 32'd0);
    check("reset_freeze", {31'd0, freeze}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    do_req("cold_rd_100",    1, 0, 32'h100, 0, 32'hDEADBEEF, 7, 6, 0);
    do_req("hit_rd_100",     1, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
    do_req("miss_rd_000",    1, 0, 32'h000, 0, 32'h11110000, 7, 6, 0);
    do_req("hit_rd_100b",    1, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
    do_req("evict_rd_200",   1, 0, 32'h200, 0, 32'h22220200, 7, 6, 0);
    do_req("keep_rd_100",    1, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
    do_req("evicted_rd_000", 1, 0, 32'h000, 0, 32'h11110000, 7, 6, 0);
    do_req("wr_hit_100",     0, 1, 32'h100, 32'h12345678, 32'h0, 7, 0, 6);
    do_req("rd_after_wr",    1, 0, 32'h100, 0, 32'h12345678, 0, 0, 0);
    do_req("wr_miss_400",    0, 1, 32'h400, 32'hCAFEF00D, 32'h0, 7, 0, 6);
    check("sram_mem_400", mem[10'h200], 32'hCAFEF00D);
    do_req("rd_400_miss",    1, 0, 32'h400, 0, 32'hCAFEF00D, 7, 6, 0);
    do_req("rw_both_100",    1, 1, 32'h100, 32'hA5A5A5A5, 32'h0, 7, 0, 6);
    do_req("rd_after_rw",    1, 0, 32'h100, 0, 32'hA5A5A5A5, 0, 0, 0);

    // Reset in the third RD_MISS cycle of a read to 0x300.
    mem_r_en = 1'b1; address = 32'h300;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!sram_mem_read && waited < 10);
    check("rst_test_rd_started", {31'd0, sram_mem_read}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_drops_sram_read", {31'd0, sram_mem_read}, 32'd0);
    mem_r_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    do_req("post_rst_rd_300", 1, 0, 32'h300, 0, 32'h33330300, 7, 6, 0);
    do_req("post_rst_rd_100", 1, 0, 32'h100, 0, 32'hA5A5A5A5, 7, 6, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
